// File: rtl/seg7_display_mux.sv
// seg7_display_mux
// Time-multiplexes a common-anode seven-segment display from a packed hex value.
// refresh_clk is treated as a slow asynchronous level. It is synchronized and
// edge-detected inside the clk_in domain. Each detected rising edge advances the scan.
// Display data is snapshotted once per frame so that a digit can never tear mid-frame.
module seg7_display_mux #(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    refresh_clk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic [2:0]              digit_sel
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_prev;
    logic                    r_init_pend;
    logic [2:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_val_s;
    logic [NUM_DIGITS-1:0]   r_dp_s;
    logic [NUM_DIGITS-1:0]   r_en_s;

    logic                    w_step;
    logic                    w_load;
    logic [3:0]              w_nibble;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_anode_next;
    logic [6:0]              w_cathode_next;
    logic                    w_dp_next;

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // A step is the first cycle in which the synchronized refresh level is seen high.
    assign w_step = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Reload the snapshot once after reset, and again whenever the scan wraps to digit 0.
    assign w_load = r_init_pend | (w_step & (r_idx == LAST_IDX));

    assign digit_sel = r_idx;

    // Synchronize the refresh level and keep its previous value for edge detection.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], refresh_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Advance the scanned digit on every step, wrapping after the last digit.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_idx <= 3'd0;
        end else if (w_step) begin
            r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Capture the display data at frame boundaries so the whole frame shows one value.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_init_pend <= 1'b1;
            r_val_s     <= '0;
            r_dp_s      <= '0;
            r_en_s      <= '0;
        end else begin
            r_init_pend <= 1'b0;
            if (w_load) begin
                r_val_s <= value;
                r_dp_s  <= dp_mask;
                r_en_s  <= digit_en;
            end
        end
    end

    // Select the current digit's nibble and drive the segments, or blank the digit when it is disabled.
    always_comb begin
        w_nibble       = r_val_s[{r_idx, 2'b00} +: 4];
        w_onehot       = NUM_DIGITS'(1) << r_idx;
        w_anode_next   = '1;
        w_cathode_next = 7'h7F;
        w_dp_next      = 1'b1;
        if (r_en_s[r_idx]) begin
            w_anode_next   = ~w_onehot;
            w_cathode_next = hex_decode(w_nibble);
            w_dp_next      = ~r_dp_s[r_idx];
        end
    end

    // Register the display drive. Reset forces it dark immediately.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            anode   <= '1;
            cathode <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            anode   <= w_anode_next;
            cathode <= w_cathode_next;
            dp      <= w_dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_display_mux.sv
// tb_seg7_display_mux
// Drives a scaled-down refresh square wave and random display data into seg7_display_mux.
// The outputs are compared every cycle against a frame-level reference model.
// The model counts refresh rising edges, and each edge takes effect a fixed number of clk_in edges later.
module tb_seg7_display_mux;

    localparam int NUM_DIGITS  = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [6:0] SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        refreshClk = 1'b0;
    logic [31:0] value = 32'h1234ABCD;
    logic [7:0]  dpMask = 8'h00;
    logic [7:0]  digitEn = 8'hFF;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic [2:0]  digitSel;

    int          assertCount = 0;
    int          failCount = 0;

    int          edgeCount = 0;
    int          mIdx = 0;
    logic [31:0] snapValue = '0;
    logic [7:0]  snapDp = '0;
    logic [7:0]  snapEn = '0;
    bit          initPend = 1'b1;
    int          pending[$];
    logic [7:0]  expAnode = 8'hFF;
    logic [6:0]  expCathode = 7'h7F;
    logic        expDp = 1'b1;

    seg7_display_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .refresh_clk(refreshClk),
        .value      (value),
        .dp_mask    (dpMask),
        .digit_en   (digitEn),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .digit_sel  (digitSel)
    );

    // 100 MHz system clock.
    always #5 clk_in = ~clk_in;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkValue("anode", {24'h0, anode}, {24'h0, expAnode});
        checkValue("cathode", {25'h0, cathode}, {25'h0, expCathode});
        checkValue("dp", {31'h0, dp}, {31'h0, expDp});
        checkValue("digit_sel", {29'h0, digitSel}, 32'(mIdx));
    endtask

    // One clk_in edge. The model is advanced using the inputs the DUT saw at this edge.
    task automatic cycle();
        bit step;
        @(posedge clk_in);
        edgeCount++;
        if (reset) begin
            if (snapEn[mIdx]) begin
                expAnode   = ~(8'd1 << mIdx);
                expCathode = SEG[(snapValue >> (4 * mIdx)) & 32'hF];
                expDp      = ~snapDp[mIdx];
            end else begin
                expAnode   = 8'hFF;
                expCathode = 7'h7F;
                expDp      = 1'b1;
            end
            step = 1'b0;
            if (pending.size() > 0 && pending[0] == edgeCount) begin
                step = 1'b1;
                void'(pending.pop_front());
            end
            if (initPend || (step && mIdx == NUM_DIGITS - 1)) begin
                snapValue = value;
                snapDp    = dpMask;
                snapEn    = digitEn;
                initPend  = 1'b0;
            end
            if (step) mIdx = (mIdx + 1) % NUM_DIGITS;
        end
        #1;
        checkOutput();
    endtask

    // Set the refresh level. A rising edge seen at the next clk_in edge moves the scan SYNC_STAGES edges after that.
    task automatic applyStimulus(input logic lvl);
        if (lvl && !refreshClk && reset) pending.push_back(edgeCount + 1 + SYNC_STAGES);
        refreshClk = lvl;
    endtask

    task automatic pulse(input int highCycles, input int lowCycles);
        applyStimulus(1'b1);
        repeat (highCycles) cycle();
        applyStimulus(1'b0);
        repeat (lowCycles) cycle();
    endtask

    task automatic assertReset();
        reset      = 1'b0;
        mIdx       = 0;
        snapValue  = '0;
        snapDp     = '0;
        snapEn     = '0;
        initPend   = 1'b1;
        pending.delete();
        expAnode   = 8'hFF;
        expCathode = 7'h7F;
        expDp      = 1'b1;
        #1;
        checkValue("reset_anode_async", {24'h0, anode}, 32'hFF);
        checkValue("reset_cathode_async", {25'h0, cathode}, 32'h7F);
        checkValue("reset_dp_async", {31'h0, dp}, 32'h1);
        checkValue("reset_digit_sel", {29'h0, digitSel}, 32'h0);
    endtask

    task automatic releaseReset();
        reset = 1'b1;
        if (refreshClk) pending.push_back(edgeCount + 1 + SYNC_STAGES);
    endtask

    initial begin
        #2;
        assertReset();
        repeat (3) cycle();
        releaseReset();

        // Snapshot loads at the first edge, and digit 0 ('D') shows at the second.
        cycle();
        checkValue("init_dark", {24'h0, anode}, 32'hFF);
        cycle();
        checkValue("init_anode", {24'h0, anode}, 32'hFE);
        checkValue("init_cathode", {25'h0, cathode}, {25'h0, 7'b1000010});
        checkValue("init_dp", {31'h0, dp}, 32'h1);

        // Walk the scan through a full frame and three digits past the wrap.
        for (int i = 0; i < 11; i++) begin
            pulse(3 + $urandom_range(0, 5), 3 + $urandom_range(0, 5));
            checkValue("walk_anode", {24'h0, anode}, {24'h0, ~(8'd1 << ((i + 1) % 8))});
        end

        // A mid-frame change is not visible until the next wrap.
        value = 32'h00000000;
        pulse(4, 4);
        checkValue("midframe_digit4", {25'h0, cathode}, {25'h0, 7'b1001100});
        pulse(4, 4);
        checkValue("midframe_digit5", {25'h0, cathode}, {25'h0, 7'b0000110});
        repeat (3) pulse(4, 4);
        checkValue("wrap_digit0_zero", {25'h0, cathode}, {25'h0, 7'b0000001});
        pulse(4, 4);
        checkValue("wrap_digit1_zero", {25'h0, cathode}, {25'h0, 7'b0000001});

        // A blanked digit and a single decimal point, both taking effect after the wrap.
        digitEn = 8'b11111011;
        dpMask  = 8'h01;
        value   = $urandom;
        repeat (7) pulse(3, 4);
        checkValue("dp_digit0", {31'h0, dp}, 32'h0);
        checkValue("anode_digit0", {24'h0, anode}, 32'hFE);
        repeat (2) pulse(3, 4);
        checkValue("blank_anode", {24'h0, anode}, 32'hFF);
        checkValue("blank_cathode", {25'h0, cathode}, 32'h7F);
        checkValue("blank_dp", {31'h0, dp}, 32'h1);

        // Random data and random refresh duty cycles.
        for (int i = 0; i < 40; i++) begin
            value   = $urandom;
            dpMask  = 8'($urandom);
            digitEn = 8'($urandom);
            pulse(3 + $urandom_range(0, 7), 3 + $urandom_range(0, 7));
        end

        // Reset in the middle of a frame darkens the display without a clock edge.
        for (int g = 0; g < 16 && mIdx != 5; g++) pulse(4, 4);
        checkValue("reach_digit5", {29'h0, digitSel}, 32'h5);
        value   = 32'h1234ABCD;
        dpMask  = 8'h00;
        digitEn = 8'hFF;
        cycle();
        assertReset();
        repeat (2) cycle();
        releaseReset();
        cycle();
        checkValue("restart_digit_sel", {29'h0, digitSel}, 32'h0);
        cycle();
        checkValue("restart_anode", {24'h0, anode}, 32'hFE);
        checkValue("restart_cathode", {25'h0, cathode}, {25'h0, 7'b1000010});

        // Refresh held high through reset release produces exactly one step.
        assertReset();
        applyStimulus(1'b1);
        repeat (2) cycle();
        releaseReset();
        repeat (2) cycle();
        checkValue("hold_high_no_step_yet", {29'h0, digitSel}, 32'h0);
        cycle();
        checkValue("hold_high_one_step", {29'h0, digitSel}, 32'h1);
        repeat (10) cycle();
        checkValue("hold_high_no_extra_step", {29'h0, digitSel}, 32'h1);
        applyStimulus(1'b0);
        repeat (4) cycle();
        checkValue("falling_edge_no_step", {29'h0, digitSel}, 32'h1);
        pulse(4, 4);
        checkValue("next_rise_step", {29'h0, digitSel}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
